theremin_sample_sequencer: RTL and testbench

Sequences one audio frame per DAC left/right clock period for the theremin tone path. It detects each rising edge of the codec's DACLRCK and requests a sample from the tone generator at the current phase over a req/ack handshake. It writes that sample to the audio core's FIFO on both channels, then advances the phase accumulator. It also owns the pitch step register, which the two freq_up_down pushbuttons adjust. It sits between the audio_0 codec core, the tone generator and the board keys.

---
 rtl/theremin_sample_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_theremin_sample_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/theremin_sample_sequencer.sv
// Per-frame audio sequencer for the theremin tone path: on each DACLRCK rise it fetches
// one generator sample at the current phase, writes it to both FIFO channels, then advances the phase.
module theremin_sample_sequencer #(
    parameter int unsigned         DATA_W      = 24,
    parameter int unsigned         PHASE_W     = 32,
    parameter logic [PHASE_W-1:0]  STEP_INIT   = 32'd1_000_000,
    parameter logic [PHASE_W-1:0]  STEP_DELTA  = 32'd10_000,
    parameter logic [PHASE_W-1:0]  STEP_MIN    = 32'd100_000,
    parameter logic [PHASE_W-1:0]  STEP_MAX    = 32'd50_000_000,
    parameter int unsigned         ACK_TIMEOUT = 255
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               daclrc,
    input  logic [1:0]         freq_up_down,
    output logic               gen_req,
    output logic [PHASE_W-1:0] gen_phase,
    input  logic               gen_ack,
    input  logic [DATA_W-1:0]  gen_sample,
    output logic               fifo_wr,
    output logic               fifo_chan,
    output logic [DATA_W-1:0]  fifo_data,
    input  logic               fifo_full,
    output logic [PHASE_W-1:0] step,
    output logic [15:0]        drop_cnt,
    output logic               busy
);

    localparam int unsigned CNT_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned STEP_W = PHASE_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WR_L     = 2'd2,
        WR_R     = 2'd3
    } state_t;

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic [CNT_W-1:0]   ack_cnt;
    logic               pending;
    logic [1:0]         drop_owed;

    logic [2:0]         lrc_sync;
    logic [1:0]         key_s1;
    logic [1:0]         key_s2;
    logic [1:0]         key_s3;

    logic               frame_edge;
    logic               key_up;
    logic               key_dn;
    logic               ack_timeout;
    logic               ev_proto;
    logic               ev_lost;
    logic [2:0]         drop_req;
    logic [STEP_W-1:0]  step_inc;
    logic [STEP_W-1:0]  step_dec;

    // Synchronizers for the asynchronous codec clock and keys, plus an edge-detect stage
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            lrc_sync <= '0;
            key_s1   <= '0;
            key_s2   <= '0;
            key_s3   <= '0;
        end else begin
            lrc_sync <= {lrc_sync[1:0], daclrc};
            key_s1   <= freq_up_down;
            key_s2   <= key_s1;
            key_s3   <= key_s2;
        end
    end

    assign frame_edge = lrc_sync[1] & ~lrc_sync[2];
    assign key_up     = ~key_s2[0] & key_s3[0];
    assign key_dn     = ~key_s2[1] & key_s3[1];

    // Step arithmetic is one bit wider so clamping sees overflow/underflow instead of a wrap
    assign step_inc = {1'b0, step} + STEP_W'(STEP_DELTA);
    assign step_dec = {1'b0, step} - STEP_W'(STEP_DELTA);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            step <= STEP_INIT;
        end else if (key_up && !key_dn) begin
            step <= (step_inc > STEP_W'(STEP_MAX)) ? STEP_MAX : step_inc[PHASE_W-1:0];
        end else if (key_dn && !key_up) begin
            step <= (step_dec[PHASE_W] || step_dec < STEP_W'(STEP_MIN)) ? STEP_MIN
                                                                        : step_dec[PHASE_W-1:0];
        end
    end

    assign ack_timeout = (state == WAIT_ACK) && !gen_ack && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign ev_proto    = ack_timeout || (((state == WR_L) || (state == WR_R)) && fifo_full);
    assign ev_lost     = frame_edge && pending && (state != IDLE);

    // Coincident drop events are folded into an owed count and drained one per cycle
    always_comb begin
        drop_req = 3'(drop_owed) + 3'(ev_proto) + 3'(ev_lost);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            drop_cnt  <= '0;
            drop_owed <= '0;
        end else if (drop_req != 3'd0) begin
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            drop_owed <= 2'(drop_req - 3'd1);
        end
    end

    // Write strobe is gated by the live full flag so a full FIFO is never written
    assign fifo_wr = ((state == WR_L) || (state == WR_R)) && !fifo_full;

    // Frame sequencing FSM
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state     <= IDLE;
            gen_req   <= 1'b0;
            gen_phase <= '0;
            fifo_chan <= 1'b0;
            fifo_data <= '0;
            phase     <= '0;
            ack_cnt   <= '0;
            pending   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_edge || pending) begin
                        gen_phase <= phase;
                        gen_req   <= 1'b1;
                        ack_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (gen_ack) begin
                        fifo_data <= gen_sample;
                        fifo_chan <= 1'b0;
                        gen_req   <= 1'b0;
                        state     <= WR_L;
                    end else if (ack_timeout) begin
                        fifo_data <= '0;
                        fifo_chan <= 1'b0;
                        gen_req   <= 1'b0;
                        state     <= WR_L;
                    end else begin
                        ack_cnt <= ack_cnt + CNT_W'(1);
                    end
                end
                WR_L: begin
                    fifo_chan <= 1'b1;
                    state     <= WR_R;
                end
                WR_R: begin
                    phase <= phase + step;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gen_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase

            // In IDLE a pending frame is consumed; an edge arriving alongside it stays pending
            if (state == IDLE) begin
                pending <= pending & frame_edge;
            end else if (frame_edge) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_theremin_sample_sequencer.sv
// Scoreboard bench for theremin_sample_sequencer: a frame-level model queues expected
// phases and FIFO writes; a monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_theremin_sample_sequencer;

    localparam int unsigned DATA_W      = 24;
    localparam int unsigned PHASE_W     = 32;
    localparam longint      STEP_INIT   = 1_000_000;
    localparam longint      STEP_DELTA  = 10_000;
    localparam longint      STEP_MIN    = 100_000;
    localparam longint      STEP_MAX    = 50_000_000;
    localparam int          ACK_TIMEOUT = 255;

    typedef struct {
        bit                chan;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        int                delay;
        logic [DATA_W-1:0] sample;
        bit                full_left;
    } resp_t;

    logic               clk_clk = 1'b0;
    logic               reset_reset;
    logic               daclrc;
    logic [1:0]         freq_up_down;
    logic               gen_req;
    logic [PHASE_W-1:0] gen_phase;
    logic               gen_ack;
    logic [DATA_W-1:0]  gen_sample;
    logic               fifo_wr;
    logic               fifo_chan;
    logic [DATA_W-1:0]  fifo_data;
    logic               fifo_full;
    logic [PHASE_W-1:0] step;
    logic [15:0]        drop_cnt;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    wr_t                 exp_wr_q[$];
    logic [PHASE_W-1:0]  exp_ph_q[$];
    resp_t               resp_q[$];

    logic [PHASE_W-1:0]  model_phase;
    longint              model_step;
    int                  model_drop;
    bit                  stale_ack = 1'b0;
    int                  wr_seen = 0;

    theremin_sample_sequencer dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .daclrc       (daclrc),
        .freq_up_down (freq_up_down),
        .gen_req      (gen_req),
        .gen_phase    (gen_phase),
        .gen_ack      (gen_ack),
        .gen_sample   (gen_sample),
        .fifo_wr      (fifo_wr),
        .fifo_chan    (fifo_chan),
        .fifo_data    (fifo_data),
        .fifo_full    (fifo_full),
        .step         (step),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    // Generator model: answers each request after its scripted delay, optionally forcing full on WR_L
    initial begin : responder
        resp_t cur;
        bit    have;
        int    wait_cnt;
        gen_ack    = 1'b0;
        gen_sample = '0;
        fifo_full  = 1'b0;
        have       = 1'b0;
        wait_cnt   = 0;
        cur        = '{delay: -1, sample: '0, full_left: 1'b0};
        forever begin
            @(posedge clk_clk);
            #1;
            if (stale_ack) begin
                gen_ack    = 1'b1;
                gen_sample = 24'hDEAD01;
                tick(1);
                gen_ack    = 1'b0;
                stale_ack  = 1'b0;
            end else if (gen_req) begin
                if (!have) begin
                    if (resp_q.size() > 0) cur = resp_q.pop_front();
                    else cur = '{delay: -1, sample: '0, full_left: 1'b0};
                    have     = 1'b1;
                    wait_cnt = 0;
                end
                wait_cnt++;
                if (cur.delay > 0 && wait_cnt >= cur.delay) begin
                    gen_ack    = 1'b1;
                    gen_sample = cur.sample;
                    tick(1);
                    gen_ack    = 1'b0;
                    have       = 1'b0;
                    if (cur.full_left) begin
                        fifo_full = 1'b1;
                        tick(1);
                        fifo_full = 1'b0;
                    end
                end
            end else begin
                have = 1'b0;
            end
        end
    end

    // Monitor: compares every request phase and every FIFO write against the scoreboard
    logic               prev_req = 1'b0;
    logic [PHASE_W-1:0] mon_ph;
    wr_t                mon_wr;
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (gen_req && !prev_req) begin
                if (exp_ph_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    mon_ph = exp_ph_q.pop_front();
                    check("gen_phase", gen_phase, mon_ph);
                end
            end
            if (fifo_wr) begin
                wr_seen++;
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_wr", 1, 0);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    check("fifo_chan", fifo_chan, mon_wr.chan);
                    check("fifo_data", fifo_data, mon_wr.data);
                end
            end
        end
        prev_req = gen_req;
    end

    // Frame-level reference: what one served frame must produce
    task automatic expect_frame(input int delay, input logic [DATA_W-1:0] smp, input bit full_l);
        logic [DATA_W-1:0] d;
        resp_q.push_back('{delay: delay, sample: smp, full_left: full_l});
        exp_ph_q.push_back(model_phase);
        d = (delay < 0) ? '0 : smp;
        if (!full_l) exp_wr_q.push_back('{chan: 1'b0, data: d});
        exp_wr_q.push_back('{chan: 1'b1, data: d});
        model_drop  += (delay < 0 ? 1 : 0) + (full_l ? 1 : 0);
        model_phase = model_phase + PHASE_W'(model_step);
    endtask

    task automatic rise_only();
        daclrc = 1'b1;
        tick(3);
        daclrc = 1'b0;
        tick(3);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while ((exp_wr_q.size() != 0 || busy || gen_req) && n < bound) begin
            tick(1);
            n++;
        end
        if (n >= bound) check("frame_done_timeout", 0, 1);
        tick(2);
    endtask

    task automatic do_frame(input int delay, input logic [DATA_W-1:0] smp, input bit full_l);
        int lat;
        int hi;
        expect_frame(delay, smp, full_l);
        daclrc = 1'b1;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!gen_req && lat < 12);
        daclrc = 1'b0;
        check("req_latency_3to4", (lat >= 3 && lat <= 4) ? 1 : 0, 1);
        if (delay < 0) begin
            hi = 1;
            tick(1);
            while (gen_req && hi < 400) begin
                hi++;
                tick(1);
            end
            check("timeout_req_cycles", hi, ACK_TIMEOUT);
        end
        wait_done(600);
        check("drop_cnt", drop_cnt, model_drop);
    endtask

    task automatic press(input logic [1:0] keys);
        freq_up_down = ~keys;
        tick(4);
        freq_up_down = 2'b11;
        tick(4);
        if (keys == 2'b01) model_step = (model_step + STEP_DELTA > STEP_MAX) ? STEP_MAX : model_step + STEP_DELTA;
        if (keys == 2'b10) model_step = (model_step - STEP_DELTA < STEP_MIN) ? STEP_MIN : model_step - STEP_DELTA;
    endtask

    task automatic model_reset();
        model_phase = '0;
        model_step  = STEP_INIT;
        model_drop  = 0;
    endtask

    initial begin : main
        int    start_wr;
        int    d;
        bit    fl;
        int    kp;
        reset_reset  = 1'b1;
        daclrc       = 1'b0;
        freq_up_down = 2'b11;
        model_reset();
        tick(3);
        check("rst_gen_req", gen_req, 0);
        check("rst_gen_phase", gen_phase, 0);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_fifo_chan", fifo_chan, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_step", step, STEP_INIT);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_busy", busy, 0);
        reset_reset = 1'b0;
        tick(5);

        // Basic frame, then a second frame at the advanced phase
        do_frame(2, 24'h123456, 1'b0);
        do_frame(3, 24'h0F0F0F, 1'b0);

        // Full during left write only
        do_frame(2, 24'hA5A5A5, 1'b1);

        // Generator never answers
        do_frame(-1, 24'h777777, 1'b0);

        // Three rises during a long stall: second served afterwards, third lost
        expect_frame(200, 24'h111111, 1'b0);
        expect_frame(3, 24'h222222, 1'b0);
        model_drop++;
        rise_only();
        tick(10);
        rise_only();
        tick(10);
        rise_only();
        wait_done(1000);
        check("drop_cnt_overrun", drop_cnt, model_drop);

        // Key presses
        repeat (5) press(2'b01);
        check("step_up5", step, model_step);
        check("step_up5_abs", step, 1_050_000);
        repeat (100) press(2'b10);
        check("step_clamp_min", step, STEP_MIN);
        press(2'b11);
        check("step_both", step, model_step);
        press(2'b01);
        check("step_after_both", step, model_step);
        do_frame(2, 24'h345678, 1'b0);
        do_frame(2, 24'h456789, 1'b0);

        // Randomized frames with random key activity between them
        repeat (12) begin
            kp = $urandom_range(0, 3);
            repeat (kp) press(2'($urandom_range(1, 3)));
            check("step_rand", step, model_step);
            d  = $urandom_range(1, 20);
            fl = ($urandom_range(0, 3) == 0);
            do_frame(d, DATA_W'($urandom), fl);
        end

        // Reset in WAIT_ACK aborts the frame; a stale ack afterwards writes nothing
        exp_ph_q.push_back(model_phase);
        daclrc = 1'b1;
        tick(6);
        daclrc = 1'b0;
        check("pre_reset_req", gen_req, 1);
        tick(4);
        reset_reset = 1'b1;
        #1;
        check("async_req_drop", gen_req, 0);
        exp_wr_q.delete();
        exp_ph_q.delete();
        resp_q.delete();
        model_reset();
        tick(2);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_step", step, STEP_INIT);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_gen_phase", gen_phase, 0);
        check("mid_rst_fifo_wr", fifo_wr, 0);
        reset_reset = 1'b0;
        tick(2);
        start_wr  = wr_seen;
        stale_ack = 1'b1;
        tick(10);
        check("stale_ack_writes", wr_seen - start_wr, 0);
        check("stale_ack_busy", busy, 0);
        do_frame(2, 24'hABCDEF, 1'b0);

        check("exp_wr_q_empty", exp_wr_q.size(), 0);
        check("exp_ph_q_empty", exp_ph_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
